// File: rtl/iter_divsqrt_if.sv
// iter_divsqrt_if: request/response bundle for the iterative divide / square-root unit
interface iter_divsqrt_if #(parameter int WIDTH = 8);
    logic             start;
    logic             op;
    logic             rm;
    logic [WIDTH-1:0] N;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             dz;
    logic             busy;
    logic             done;
    modport master (output start, op, rm, N, D, input Q, R, dz, busy, done);
    modport slave  (input start, op, rm, N, D, output Q, R, dz, busy, done);
endinterface

// File: rtl/iter_divsqrt.sv
// iter_divsqrt: multi-cycle unsigned divide (radix-2 restoring) or square root (digit-by-digit) with optional rounding
module iter_divsqrt #(parameter int WIDTH = 8) (
    input  logic          clk,
    input  logic          reset,
    iter_divsqrt_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, ROUND, DONE} state_t;
    localparam int CW = $clog2(WIDTH + 1);
    state_t           state, state_nx;
    logic [WIDTH-1:0] n, d, q, rem, q_out, r_out, diff;
    logic [WIDTH+1:0] sh, sub;
    logic [CW-1:0]    cnt;
    logic             op, rm, dz, ge, rnd, dzc;
    // state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    // next state: a zero divisor skips the iteration phase entirely
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE  ? (bus.start ? ((!bus.op && bus.D == '0) ? ROUND : RUN) : IDLE) :
                   state == RUN   ? (cnt == CW'(1) ? ROUND : RUN) :
                   state == ROUND ? DONE : IDLE;
    end
    // one iteration step; sqrt brings down two radicand bits against 4*root+1, div one bit against D
    always_comb begin
        sh   = op ? {rem, n[WIDTH-1:WIDTH-2]} : {1'b0, rem, n[WIDTH-1]};
        sub  = op ? {q, 2'b01} : {2'b00, d};
        ge   = sh >= sub;
        diff = sh[WIDTH-1:0] - sub[WIDTH-1:0];
        rnd  = rm & (op ? rem > q : {rem, 1'b0} >= {1'b0, d});
        dzc  = !op && d == '0;
    end
    // operand latch, iteration datapath and result registers
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            n     <= '0;
            d     <= '0;
            q     <= '0;
            rem   <= '0;
            cnt   <= '0;
            op    <= 1'b0;
            rm    <= 1'b0;
            q_out <= '0;
            r_out <= '0;
            dz    <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            n   <= bus.N;
            d   <= bus.D;
            op  <= bus.op;
            rm  <= bus.rm;
            q   <= '0;
            rem <= '0;
            cnt <= bus.op ? CW'(WIDTH / 2) : CW'(WIDTH);
        end else if (state == RUN) begin
            rem <= ge ? diff : sh[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], ge};
            n   <= op ? n << 2 : n << 1;
            cnt <= cnt - CW'(1);
        end else if (state == ROUND) begin
            q_out <= dzc ? '1 : q + {{(WIDTH-1){1'b0}}, rnd};
            r_out <= dzc ? n : rem;
            dz    <= dzc;
        end
    assign bus.Q    = q_out;
    assign bus.R    = r_out;
    assign bus.dz   = dz;
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
endmodule

// File: doc/iter_divsqrt.md
Name: iter_divsqrt

Overview:
- Parametrised iterative integer divide / square-root unit with selectable rounding.
- Successor to the fixed single-operation divider.
- Adds generic WIDTH, op select (div/sqrt), rm rounding, start/busy/done handshake, remainder output and divide-by-zero flag.
- Sits beside the datapath as a multi-cycle arithmetic slave; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits; must be even and >= 4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = divide N/D, 1 = square root of N (D ignored).
- rm  in  1  0 = truncate, 1 = round-to-nearest, ties up.
- N  in  WIDTH  dividend / radicand, unsigned.
- D  in  WIDTH  divisor, unsigned.
- Q  out  WIDTH  quotient or root (root zero-extended), rounded per rm.
- R  out  WIDTH  unrounded remainder: N - Q_trunc*D, or N - Q_trunc^2.
- dz  out  1  divide-by-zero flag for the last result.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; Q/R/dz valid from this cycle.

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE; Q, R, dz, busy, done all 0; internal registers cleared. Aborts any operation in flight; no done is produced for it.
- FSM states: IDLE, RUN, ROUND, DONE.
- IDLE: on start = 1 at edge k, latch N, D, op, rm.
  - op = 0, D = 0: go to ROUND, skipping RUN.
  - Otherwise go to RUN with iteration count ITER = WIDTH (div) or WIDTH/2 (sqrt).
- RUN: one iteration per clock, then ROUND after ITER edges.
  - Div: radix-2 restoring, MSB first.
  - Sqrt: digit-by-digit restoring, 2 radicand bits per iteration.
- ROUND: one cycle; applies rounding and registers Q/R/dz; then DONE.
- DONE: done = 1 for exactly one cycle; next state IDLE.
- Latency (start-high cycle to done-high cycle, inclusive count from start cycle + 0):
  - Div: WIDTH+2 cycles.
  - Sqrt: WIDTH/2+2 cycles.
  - Divide-by-zero: 2 cycles.
- start is ignored while busy; inputs may change freely after the start cycle.
- start high in the DONE cycle is ignored. Back-to-back issue: start in the IDLE cycle immediately after DONE is accepted.
- Outputs Q/R/dz hold their value from DONE until the next ROUND writes them; they are not cleared on start.
- Rounding, rm = 1:
  - Div: Q = Q_trunc + 1 if 2*R >= D, compared at WIDTH+1 bits (no overflow). Increment cannot wrap, because Q_trunc = all-ones implies D = 1, R = 0.
  - Sqrt: Q = Q_trunc + 1 if R > Q_trunc.
  - R always reports the unrounded remainder.
- Divide-by-zero: Q = all ones, R = N, dz = 1; rm ignored.
- dz = 0 for every sqrt and every nonzero-divisor divide.
- N = 0: Q = 0, R = 0 for both ops, full normal latency.
- Reset asserted mid-RUN, then released: unit is in IDLE with outputs 0. The next start executes normally.

Test Plan:
- WIDTH=8, op=0, N=100, D=7, rm=0 -> done 10 cycles after start, Q=14, R=2, dz=0. Repeat with rm=1 -> Q=14 (2R=4 < 7).
- op=0, N=100, D=8, rm=1 -> Q=13, R=4. N=255, D=1, rm=1 -> Q=255, R=0, no wrap.
- op=1, rm=1: N=200 -> Q=14, R=4; N=211 -> Q=15, R=15; N=210 -> Q=14, R=14. Each done 6 cycles after start. N=0 -> Q=0, R=0.
- op=0, N=55, D=0 -> done 2 cycles after start, Q=255, R=55, dz=1. Next op (100/7) -> dz=0.
- start pulsed every cycle while busy with different operands -> only the first is executed, exactly one done, busy high throughout. start held continuously -> ops issue back-to-back with one IDLE cycle between done pulses.
- reset driven low in the 4th RUN cycle of 100/7 -> Q, R, dz, busy, done go 0 immediately, with no clock edge needed, and no done follows. After release, 100/8 rm=0 -> Q=12, R=4.
